// File: rtl/regfile_master_pkg.sv
// rtl/regfile_master_pkg.sv - shared op codes, FSM states and width defaults for regfile_master
package regfile_master_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 4;

    typedef enum logic [2:0] {
        OP_MOV = 3'd0,
        OP_ADD = 3'd1,
        OP_SUB = 3'd2,
        OP_AND = 3'd3,
        OP_OR  = 3'd4,
        OP_XOR = 3'd5,
        OP_LDI = 3'd6,
        OP_RD  = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_A,
        S_RD_B,
        S_EXEC,
        S_WR_SETUP,
        S_WR_PULSE,
        S_RESP
    } state_e;

endpackage

// File: rtl/regfile_alu.sv
// rtl/regfile_alu.sv - combinational result/flag generator for register operations
module regfile_alu
    import regfile_master_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  op_e               op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] imm,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              carry
);

    logic [DATA_W:0] wide;

    // One extra bit: carry-out for ADD, wrap-around borrow for SUB, zero otherwise
    always_comb begin
        wide = '0;
        case (op)
            OP_MOV: wide = {1'b0, a};
            OP_ADD: wide = {1'b0, a} + {1'b0, b};
            OP_SUB: wide = {1'b0, a} - {1'b0, b};
            OP_AND: wide = {1'b0, a & b};
            OP_OR:  wide = {1'b0, a | b};
            OP_XOR: wide = {1'b0, a ^ b};
            OP_LDI: wide = {1'b0, imm};
            OP_RD:  wide = {1'b0, a};
            default: wide = '0;
        endcase
        result = wide[DATA_W-1:0];
        carry  = wide[DATA_W];
        zero   = (wide[DATA_W-1:0] == '0);
    end

endmodule

// File: rtl/regfile_master.sv
// rtl/regfile_master.sv - sequences one register operation at a time over a single-port register file
module regfile_master
    import regfile_master_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_rd,
    input  logic [ADDR_W-1:0] req_rs,
    input  logic [ADDR_W-1:0] req_rt,
    input  logic [DATA_W-1:0] req_imm,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_zero,
    output logic              resp_carry,
    output logic [ADDR_W-1:0] rf_address,
    output logic [DATA_W-1:0] rf_data_write,
    output logic              rf_write_en,
    input  logic [DATA_W-1:0] rf_data_read
);

    state_e            state, next_state;
    op_e               op_q;
    logic [ADDR_W-1:0] rd_q, rt_q;
    logic [DATA_W-1:0] imm_q, a_q, b_q;
    logic [DATA_W-1:0] alu_result;
    logic              alu_zero, alu_carry;
    logic              two_operand;

    regfile_alu #(.DATA_W(DATA_W)) u_alu (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .imm    (imm_q),
        .result (alu_result),
        .zero   (alu_zero),
        .carry  (alu_carry)
    );

    assign two_operand = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_AND) ||
                         (op_q == OP_OR)  || (op_q == OP_XOR);
    assign req_ready   = (state == S_IDLE);
    assign resp_valid  = (state == S_RESP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:     if (req_valid) next_state = (req_op == OP_LDI) ? S_WR_SETUP : S_RD_A;
            S_RD_A:     next_state = two_operand ? S_RD_B : S_EXEC;
            S_RD_B:     next_state = S_EXEC;
            S_EXEC:     next_state = (op_q == OP_RD) ? S_RESP : S_WR_SETUP;
            S_WR_SETUP: next_state = S_WR_PULSE;
            S_WR_PULSE: next_state = S_RESP;
            S_RESP:     if (resp_ready) next_state = S_IDLE;
            default:    next_state = S_IDLE;
        endcase
    end

    // Address/data only move in states where rf_write_en is low, so the write edge sees stable inputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q          <= OP_MOV;
            rd_q          <= '0;
            rt_q          <= '0;
            imm_q         <= '0;
            a_q           <= '0;
            b_q           <= '0;
            resp_data     <= '0;
            resp_zero     <= 1'b0;
            resp_carry    <= 1'b0;
            rf_address    <= '0;
            rf_data_write <= '0;
            rf_write_en   <= 1'b0;
        end else begin
            rf_write_en <= (next_state == S_WR_PULSE);
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        op_q  <= op_e'(req_op);
                        rd_q  <= req_rd;
                        rt_q  <= req_rt;
                        imm_q <= req_imm;
                        if (req_op == OP_LDI) begin
                            rf_address    <= req_rd;
                            rf_data_write <= req_imm;
                            resp_data     <= req_imm;
                            resp_zero     <= (req_imm == '0);
                            resp_carry    <= 1'b0;
                        end else begin
                            rf_address <= req_rs;
                        end
                    end
                end
                S_RD_A: begin
                    a_q <= rf_data_read;
                    if (two_operand) rf_address <= rt_q;
                end
                S_RD_B: b_q <= rf_data_read;
                S_EXEC: begin
                    resp_data  <= alu_result;
                    resp_zero  <= alu_zero;
                    resp_carry <= alu_carry;
                    if (op_q != OP_RD) begin
                        rf_address    <= rd_q;
                        rf_data_write <= alu_result;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_master.sv
// tb/tb_regfile_master.sv - directed-vector bench for regfile_master with a behavioural register file
module tb_regfile_master;
    import regfile_master_pkg::*;

    logic       clk, rst;
    logic       req_valid, req_ready;
    logic [2:0] req_op;
    logic [3:0] req_rd, req_rs, req_rt;
    logic [7:0] req_imm;
    logic       resp_valid, resp_ready;
    logic [7:0] resp_data;
    logic       resp_zero, resp_carry;
    logic [3:0] rf_address;
    logic [7:0] rf_data_write;
    logic       rf_write_en;
    logic [7:0] rf_data_read;

    logic [7:0] regs [16];
    int         we_rises;
    int         n_vec, n_bad;
    logic       tr_we   [32];
    logic [3:0] tr_addr [32];
    logic [7:0] tr_data [32];

    regfile_master dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_rd(req_rd), .req_rs(req_rs), .req_rt(req_rt), .req_imm(req_imm),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_zero(resp_zero), .resp_carry(resp_carry),
        .rf_address(rf_address), .rf_data_write(rf_data_write),
        .rf_write_en(rf_write_en), .rf_data_read(rf_data_read)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rf_data_read = regs[rf_address];

    always @(posedge rf_write_en) begin
        regs[rf_address] = rf_data_write;
        we_rises = we_rises + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [3:0] rd,
                          input logic [3:0] rs, input logic [3:0] rt, input logic [7:0] imm,
                          input int exp_lat, input logic [7:0] exp_data,
                          input logic exp_zero, input logic exp_carry, input int hold);
        int lat;
        int w0;
        @(negedge clk);
        chk({tag, " req_ready"}, req_ready, 1);
        req_op = op; req_rd = rd; req_rs = rs; req_rt = rt; req_imm = imm;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        w0  = we_rises;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            tr_we[lat]   = rf_write_en;
            tr_addr[lat] = rf_address;
            tr_data[lat] = rf_data_write;
        end while (!resp_valid && lat < 30);
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " data"}, resp_data, exp_data);
        chk({tag, " zero"}, resp_zero, exp_zero);
        chk({tag, " carry"}, resp_carry, exp_carry);
        chk({tag, " writes"}, we_rises - w0, (op == 3'd7) ? 0 : 1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, " hold valid"}, resp_valid, 1);
            chk({tag, " hold data"}, resp_data, exp_data);
            chk({tag, " hold ready"}, req_ready, 0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
    endtask

    initial begin
        int w0;
        n_vec = 0; n_bad = 0; we_rises = 0;
        for (int i = 0; i < 16; i++) regs[i] = 8'h00;
        regs[1] = 8'd28; regs[2] = 8'd64; regs[4] = 8'd128; regs[11] = 8'd128; regs[15] = 8'd7;
        rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
        req_op = 3'd0; req_rd = 4'd0; req_rs = 4'd0; req_rt = 4'd0; req_imm = 8'd0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        repeat (2) @(negedge clk);

        #2 rst = 1'b1;
        #1;
        chk("idle rst req_ready", req_ready, 1);
        chk("idle rst resp_valid", resp_valid, 0);
        chk("idle rst write_en", rf_write_en, 0);
        chk("idle rst address", rf_address, 0);
        chk("idle rst resp_data", resp_data, 0);
        @(negedge clk) rst = 1'b0;

        run_op("add92", 3'd1, 4'd3, 4'd1, 4'd2, 8'd0, 6, 8'd92, 1'b0, 1'b0, 0);
        chk("add92 addr c4", tr_addr[4], 3);
        chk("add92 addr c5", tr_addr[5], 3);
        chk("add92 data c4", tr_data[4], 92);
        chk("add92 data c5", tr_data[5], 92);
        chk("add92 we c3", tr_we[3], 0);
        chk("add92 we c4", tr_we[4], 0);
        chk("add92 we c5", tr_we[5], 1);
        chk("add92 we c6", tr_we[6], 0);
        run_op("rd3", 3'd7, 4'd0, 4'd3, 4'd0, 8'd0, 3, 8'd92, 1'b0, 1'b0, 0);
        run_op("add_wrap", 3'd1, 4'd6, 4'd4, 4'd11, 8'd0, 6, 8'd0, 1'b1, 1'b1, 0);
        run_op("sub_borrow", 3'd2, 4'd5, 4'd1, 4'd2, 8'd0, 6, 8'd220, 1'b0, 1'b1, 0);
        run_op("mov", 3'd0, 4'd7, 4'd1, 4'd0, 8'd0, 5, 8'd28, 1'b0, 1'b0, 0);
        run_op("rd7", 3'd7, 4'd0, 4'd7, 4'd0, 8'd0, 3, 8'd28, 1'b0, 1'b0, 0);
        run_op("and", 3'd3, 4'd8, 4'd1, 4'd2, 8'd0, 6, 8'd0, 1'b1, 1'b0, 0);
        run_op("xor", 3'd5, 4'd9, 4'd1, 4'd2, 8'd0, 6, 8'd92, 1'b0, 1'b0, 0);
        run_op("ldi", 3'd6, 4'd0, 4'd0, 4'd0, 8'hA5, 3, 8'hA5, 1'b0, 1'b0, 3);
        run_op("rd0", 3'd7, 4'd0, 4'd0, 4'd0, 8'd0, 3, 8'hA5, 1'b0, 1'b0, 0);

        @(negedge clk);
        req_op = 3'd1; req_rd = 4'd1; req_rs = 4'd2; req_rt = 4'd15; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        w0 = we_rises;
        repeat (3) @(negedge clk);
        chk("rst exec address", rf_address, 15);
        rst = 1'b1;
        #1;
        chk("rst exec req_ready", req_ready, 1);
        chk("rst exec resp_valid", resp_valid, 0);
        chk("rst exec write_en", rf_write_en, 0);
        chk("rst exec address0", rf_address, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("rst exec no write", we_rises - w0, 0);
        chk("rst exec idle", req_ready, 1);
        run_op("rd1", 3'd7, 4'd0, 4'd1, 4'd0, 8'd0, 3, 8'd28, 1'b0, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
